data_mem_port: RTL and testbench
================================

DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the maximum cycles spent in WAIT before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 data_addr  in  32  core access address (ALU result).
REQ-005 should_read_mem  in  1  core load request, level.
REQ-006 should_write_mem  in  1  core store request, level.
REQ-007 mem_write_data  in  32  core store data.
REQ-008 mem_read_data  out  32  load data returned to core.
REQ-009 mem_busy  out  1  stall to core; while high the core holds PC and request.
REQ-010 mem_fault  out  1  sticky error flag.
REQ-011 bus_req  out  1  bus request, held until bus_ack or bus_err.
REQ-012 bus_we  out  1  1 = write, 0 = read.
REQ-013 bus_addr  out  32  word address {data_addr[31:2],2'b00}.
REQ-014 bus_wdata  out  32  write data.
REQ-015 bus_ack  in  1  one-cycle completion pulse.
REQ-016 bus_err  in  1  one-cycle error completion pulse.
REQ-017 bus_rdata  in  32  read data, valid with bus_ack.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-019 IDLE: mem_busy SHALL equal should_read_mem|should_write_mem combinationally; on a request, the block SHALL latch addr, wdata, and we (we = should_write_mem), then go to WAIT.
REQ-020 Simultaneous read and write requests SHALL be treated as a write.
REQ-021 WAIT: bus_req=1, bus_we/bus_addr/bus_wdata SHALL be driven from the latched values and stay stable; mem_busy=1.
REQ-022 WAIT with bus_ack=1 SHALL capture bus_rdata (reads only; writes leave the capture register unchanged) and go to DONE.
REQ-023 WAIT with bus_err=1 (priority over bus_ack) SHALL capture 0, set mem_fault, and go to DONE.
REQ-024 DONE: bus_req=0 and mem_busy=0 so the core advances; mem_read_data SHALL present the captured word; the next state SHALL be IDLE unconditionally, with requests ignored during DONE.
REQ-025 mem_read_data SHALL hold the last captured word in all states.
REQ-026 bus_ack/bus_err SHALL be ignored outside WAIT.
REQ-027 Minimum access latency SHALL be 2 cycles of mem_busy (IDLE + one WAIT cycle with immediate ack); the DONE cycle follows.
REQ-028 mem_fault SHALL remain 1 until reset.

Reset
REQ-029 Asserting reset SHALL force IDLE immediately, including mid-transaction, dropping bus_req asynchronously.
REQ-030 On reset, mem_read_data, the latched addr/wdata/we, bus outputs, mem_fault, and the timeout counter SHALL be 0.
REQ-031 After reset deassertion, the first posedge SHALL evaluate IDLE normally.

Configuration
REQ-032 With macro DATA_MEM_PORT_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without ack/err.
REQ-033 With DATA_MEM_PORT_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the block SHALL behave as bus_err: capture 0, set mem_fault, go to DONE.
REQ-034 Without the macro, no counter SHALL exist and WAIT SHALL persist indefinitely until ack/err.

Verification
REQ-035 Read at 0x0000_1004, ack after 3 WAIT cycles with bus_rdata=0xDEAD_BEEF -> bus_addr=0x0000_1004, bus_we=0, mem_busy high 4 cycles, DONE shows mem_read_data=0xDEAD_BEEF.
REQ-036 Write 0x1234_5678 to 0x0000_2007 with read also asserted -> bus_we=1, bus_addr=0x0000_2004, bus_wdata=0x1234_5678; mem_read_data unchanged.
REQ-037 Read with bus_err and bus_ack both 1 in WAIT -> mem_read_data=0, mem_fault=1, and it stays 1 through a later good access.
REQ-038 Reset asserted in the second WAIT cycle -> bus_req low before the next edge; all outputs 0; a stray bus_ack after reset causes no state change.
REQ-039 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> DONE after 4 WAIT cycles, mem_fault=1; macro undefined -> still WAIT after 300 cycles.
REQ-040 Back-to-back reads held high across DONE -> exactly two bus_req transactions, with a one-cycle bus_req=0 gap in DONE.

Source files
------------

// File: rtl/data_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_port_if
//  Brief    : Bus-side handshake bundle between the data memory port and the
//             external memory/bus slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface data_mem_port_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_port
//  Brief    : Core load/store to single-outstanding bus bridge (IDLE/WAIT/DONE).
//             Optional WAIT watchdog enabled by DATA_MEM_PORT_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire         clk,
    input  wire         reset,
    input  wire  [31:0] data_addr,
    input  wire         should_read_mem,
    input  wire         should_write_mem,
    input  wire  [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_busy,
    output logic        mem_fault,
    data_mem_port_if.master bus
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        w_req;
    logic        w_timeout;
    logic [1:0]  w_unused_lsb;

    assign w_req        = should_read_mem | should_write_mem;
    assign w_unused_lsb = data_addr[1:0];

`ifdef DATA_MEM_PORT_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Fires on the last permitted WAIT cycle so DONE follows exactly
    // TIMEOUT_CYCLES WAIT cycles after entry.
    assign w_timeout = (r_state == C_WAIT) && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (r_state != C_WAIT) begin
            r_cnt <= 8'd0;
        end else if (!bus.bus_ack && !bus.bus_err) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE:  if (w_req) w_next = C_WAIT;
            C_WAIT:  if (bus.bus_ack || bus.bus_err || w_timeout) w_next = C_DONE;
            C_DONE:  w_next = C_IDLE;
            default: w_next = C_IDLE;
        endcase
    end

    always_comb begin
        mem_busy    = 1'b0;
        bus.bus_req = 1'b0;
        case (r_state)
            C_IDLE: mem_busy = w_req;
            C_WAIT: begin
                mem_busy    = 1'b1;
                bus.bus_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and response capture; err outranks ack, ack outranks timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_req) begin
                        r_addr  <= {data_addr[31:2], 2'b00};
                        r_wdata <= mem_write_data;
                        r_we    <= should_write_mem;
                    end
                end
                C_WAIT: begin
                    if (bus.bus_err || (!bus.bus_ack && w_timeout)) begin
                        r_rdata <= 32'd0;
                        r_fault <= 1'b1;
                    end else if (bus.bus_ack && !r_we) begin
                        r_rdata <= bus.bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign mem_read_data = r_rdata;
    assign mem_fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_port
//  Brief    : Scoreboard bench for data_mem_port (reads, writes, errors,
//             async reset, watchdog, back-to-back).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_addr;
    logic        should_read_mem;
    logic        should_write_mem;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_busy;
    logic        mem_fault;

    data_mem_port_if bus ();

    data_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_addr        (data_addr),
        .should_read_mem  (should_read_mem),
        .should_write_mem (should_write_mem),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_busy         (mem_busy),
        .mem_fault        (mem_fault),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rd;
    logic        model_fault;

    int   n_txn    = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (bus.bus_req === 1'b1 && prev_req !== 1'b1) n_txn++;
        prev_req = bus.bus_req;
    end

    // Drives one core request and plays the bus slave; responds in WAIT cycle
    // number resp_after (0 = never). Returns what was observed.
    task automatic run_access(
        input  logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
        input  int resp_after, input logic ack, input logic err, input logic [31:0] rdata,
        input  logic hold,
        output int busy_cyc, output int waits, output logic [31:0] o_addr,
        output logic [31:0] o_wdata, output logic o_we, output logic stable,
        output logic [31:0] o_rd, output logic done_ok);
        busy_cyc = 0; waits = 0; done_ok = 1'b0; stable = 1'b1;
        o_addr = 'x; o_wdata = 'x; o_we = 1'bx; o_rd = 'x;
        should_read_mem = rd; should_write_mem = wr; data_addr = addr; mem_write_data = wdata;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mem_busy === 1'b1) busy_cyc++;
            if (bus.bus_req === 1'b1) begin
                if (waits > 0 && (o_addr !== bus.bus_addr || o_wdata !== bus.bus_wdata || o_we !== bus.bus_we))
                    stable = 1'b0;
                waits++;
                o_addr = bus.bus_addr; o_wdata = bus.bus_wdata; o_we = bus.bus_we;
                if (waits == resp_after) begin
                    bus.bus_ack = ack; bus.bus_err = err; bus.bus_rdata = rdata;
                end
            end else if (waits > 0 && mem_busy === 1'b0) begin
                o_rd = mem_read_data;
                done_ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
        end
        if (!hold || !done_ok) begin
            should_read_mem = 1'b0; should_write_mem = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        should_read_mem = 1'b0; should_write_mem = 1'b0;
        data_addr = 32'h0; mem_write_data = 32'h0;
        bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req: got %b want 0", bus.bus_req); end
        n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", mem_read_data); end
        n_cmp++; if (mem_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", mem_fault); end
        n_cmp++; if ({bus.bus_we, bus.bus_addr, bus.bus_wdata} !== 65'h0) begin
            n_bad++; $display("FAIL rst_bus_out: got we=%b addr=%h wdata=%h want 0", bus.bus_we, bus.bus_addr, bus.bus_wdata); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", mem_busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_rd = 32'h0; model_fault = 1'b0;
    endtask

    task automatic test_read();
        int bc, w; logic [31:0] a, wd, rdv, exp; logic we, st, ok;
        model_rd = 32'hDEAD_BEEF;
        exp_q.push_back(model_rd);
        run_access(1'b0, 1'b1, 32'h0000_1004, 32'h0, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL read_done: got %b want 1", ok); end
        n_cmp++; if (bc != 4) begin n_bad++; $display("FAIL read_busy_cycles: got %0d want 4", bc); end
        n_cmp++; if (a !== 32'h0000_1004) begin n_bad++; $display("FAIL read_bus_addr: got %h want 00001004", a); end
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL read_bus_we: got %b want 0", we); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL read_bus_stable: got %b want 1", st); end
        n_cmp++; if (rdv !== exp) begin n_bad++; $display("FAIL read_data: got %h want %h", rdv, exp); end
        n_cmp++; if (mem_read_data !== exp) begin n_bad++; $display("FAIL read_data_hold: got %h want %h", mem_read_data, exp); end
    endtask

    task automatic test_write();
        int bc, w; logic [31:0] a, wd, rdv, exp; logic we, st, ok;
        exp_q.push_back(model_rd);
        run_access(1'b1, 1'b1, 32'h0000_2007, 32'h1234_5678, 1, 1'b1, 1'b0, 32'hAAAA_5555, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL write_done: got %b want 1", ok); end
        n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL write_bus_we: got %b want 1", we); end
        n_cmp++; if (a !== 32'h0000_2004) begin n_bad++; $display("FAIL write_bus_addr: got %h want 00002004", a); end
        n_cmp++; if (wd !== 32'h1234_5678) begin n_bad++; $display("FAIL write_bus_wdata: got %h want 12345678", wd); end
        n_cmp++; if (bc != 2) begin n_bad++; $display("FAIL write_busy_cycles: got %0d want 2", bc); end
        n_cmp++; if (rdv !== exp) begin n_bad++; $display("FAIL write_rdata_kept: got %h want %h", rdv, exp); end
    endtask

    task automatic test_error();
        int bc, w; logic [31:0] a, wd, rdv, exp; logic we, st, ok;
        model_rd = 32'h0; model_fault = 1'b1;
        exp_q.push_back(model_rd);
        run_access(1'b0, 1'b1, 32'h0000_3000, 32'h0, 2, 1'b1, 1'b1, 32'h5555_AAAA, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL err_done: got %b want 1", ok); end
        n_cmp++; if (rdv !== exp) begin n_bad++; $display("FAIL err_rdata: got %h want %h", rdv, exp); end
        n_cmp++; if (mem_fault !== model_fault) begin n_bad++; $display("FAIL err_fault: got %b want %b", mem_fault, model_fault); end
        model_rd = 32'h0BAD_F00D;
        exp_q.push_back(model_rd);
        run_access(1'b0, 1'b1, 32'h0000_3004, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (rdv !== exp) begin n_bad++; $display("FAIL err_next_rdata: got %h want %h", rdv, exp); end
        n_cmp++; if (mem_fault !== model_fault) begin n_bad++; $display("FAIL err_fault_sticky: got %b want %b", mem_fault, model_fault); end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        should_read_mem = 1'b1; data_addr = 32'h0000_4000; mem_write_data = 32'hFFFF_0000;
        for (int c = 0; c < 20 && w < 2; c++) begin
            @(negedge clk);
            if (bus.bus_req === 1'b1) w++;
        end
        n_cmp++; if (w != 2) begin n_bad++; $display("FAIL rstmid_reach_wait2: got %0d want 2", w); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (bus.bus_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_bus_req: got %b want 0", bus.bus_req); end
        n_cmp++; if ({mem_read_data, mem_fault} !== 33'h0) begin
            n_bad++; $display("FAIL rstmid_core_out: got rdata=%h fault=%b want 0", mem_read_data, mem_fault); end
        n_cmp++; if ({bus.bus_we, bus.bus_addr, bus.bus_wdata} !== 65'h0) begin
            n_bad++; $display("FAIL rstmid_bus_out: got we=%b addr=%h wdata=%h want 0", bus.bus_we, bus.bus_addr, bus.bus_wdata); end
        should_read_mem = 1'b0;
        #1;
        n_cmp++; if (mem_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", mem_busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_rd = 32'h0; model_fault = 1'b0;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.bus_req, mem_busy, mem_fault} !== 3'b000 || mem_read_data !== model_rd) begin
            n_bad++; $display("FAIL stray_ack: got req=%b busy=%b fault=%b rdata=%h want 0/0/0/%h",
                              bus.bus_req, mem_busy, mem_fault, mem_read_data, model_rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
`ifdef DATA_MEM_PORT_TIMEOUT_EN
        int bc, w; logic [31:0] a, wd, rdv, exp; logic we, st, ok;
        model_rd = 32'h0; model_fault = 1'b1;
        exp_q.push_back(model_rd);
        run_access(1'b0, 1'b1, 32'h0000_5000, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tmo_done: got %b want 1", ok); end
        n_cmp++; if (w != TO) begin n_bad++; $display("FAIL tmo_wait_cycles: got %0d want %0d", w, TO); end
        n_cmp++; if (rdv !== exp) begin n_bad++; $display("FAIL tmo_rdata: got %h want %h", rdv, exp); end
        n_cmp++; if (mem_fault !== model_fault) begin n_bad++; $display("FAIL tmo_fault: got %b want %b", mem_fault, model_fault); end
`else
        logic [31:0] exp;
        should_read_mem = 1'b1; data_addr = 32'h0000_5000;
        repeat (300) @(negedge clk);
        n_cmp++; if (bus.bus_req !== 1'b1 || mem_busy !== 1'b1) begin
            n_bad++; $display("FAIL notmo_still_wait: got req=%b busy=%b want 1/1", bus.bus_req, mem_busy); end
        model_rd = 32'h600D_600D;
        exp_q.push_back(model_rd);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h600D_600D;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++; if (mem_read_data !== exp || mem_busy !== 1'b0) begin
            n_bad++; $display("FAIL notmo_late_ack: got rdata=%h busy=%b want %h/0", mem_read_data, mem_busy, exp); end
        n_cmp++; if (mem_fault !== model_fault) begin n_bad++; $display("FAIL notmo_fault: got %b want %b", mem_fault, model_fault); end
        should_read_mem = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_back_to_back();
        int bc, w, t0; logic [31:0] a, wd, rdv, exp; logic we, st, ok;
        t0 = n_txn;
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0002);
        run_access(1'b0, 1'b1, 32'h0000_6000, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || rdv !== exp) begin n_bad++; $display("FAIL b2b_first: got done=%b rdata=%h want 1/%h", ok, rdv, exp); end
        run_access(1'b0, 1'b1, 32'h0000_6000, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0002, 1'b0,
                   bc, w, a, wd, we, st, rdv, ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || rdv !== exp) begin n_bad++; $display("FAIL b2b_second: got done=%b rdata=%h want 1/%h", ok, rdv, exp); end
        n_cmp++; if (bc != 2) begin n_bad++; $display("FAIL b2b_second_busy: got %0d want 2", bc); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (n_txn - t0 != 2) begin n_bad++; $display("FAIL b2b_txn_count: got %0d want 2", n_txn - t0); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_error();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
